bin2bcd16_8421: RTL and testbench

BIN2BCD16_8421 -- requirements
Module: bin2bcd16_8421

---
 rtl/bin2bcd16_8421.sv | 122 ++++++++++++
 tb/tb_bin2bcd16_8421.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bin2bcd16_8421.sv
// bin2bcd16_8421: sequential binary to 4-digit 8421 BCD converter (double dabble).
//
// A start pulse in IDLE captures `bin` and runs BIN_W shift/add-3 steps over a
// 5-digit accumulator. The low four digits land on Y and a non-zero fifth digit
// raises ovf. Y/ovf only change on the edge that enters DONE, so no partial
// result is ever visible.
//
// Parameters:
//   BIN_W   binary operand width, 4..16
// Ports:
//   clk     clock, rising edge
//   rst_n   synchronous active-low reset
//   start   conversion request, honoured in IDLE only
//   bin     unsigned operand, captured when start is accepted
//   Y       BCD result, Y[15:12] thousands .. Y[3:0] units
//   ovf     captured operand was above 9999
//   busy    high while shifting
//   done    one-cycle pulse when Y/ovf are newly valid
//
// Build option: define BIN2BCD_SAT_EN to force Y to 16'h9999 on overflow
// (default: Y carries the value mod 10000).
module bin2bcd16_8421 #(
  parameter int unsigned BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic [15:0]      Y,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q;
  logic [BIN_W-1:0] opnd_q;
  logic [19:0]      acc_q;
  logic [4:0]       cnt_q;

  logic [19:0]       acc_adj;
  logic [BIN_W+19:0] shifted;
  logic [19:0]       acc_shift;
  logic [BIN_W-1:0]  opnd_shift;
  logic              last_shift;
  logic              ovf_load;
  logic [15:0]       y_load;

  // Add-3 correction on every digit >= 5 before the shift.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 5; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    shifted    = {acc_adj, opnd_q} << 1;
    acc_shift  = shifted[BIN_W+19:BIN_W];
    opnd_shift = shifted[BIN_W-1:0];
    last_shift = (cnt_q == 5'(BIN_W - 1));
    // Result is taken from the post-shift accumulator so Y is valid on the
    // same edge that enters DONE.
    ovf_load   = (acc_shift[19:16] != 4'd0);
`ifdef BIN2BCD_SAT_EN
    y_load     = ovf_load ? 16'h9999 : acc_shift[15:0];
`else
    y_load     = acc_shift[15:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      Y       <= 16'h0000;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            opnd_q  <= bin;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          acc_q  <= acc_shift;
          opnd_q <= opnd_shift;
          cnt_q  <= cnt_q + 5'd1;
          if (last_shift) begin
            Y       <= y_load;
            ovf     <= ovf_load;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd16_8421.sv
// Directed bench for bin2bcd16_8421 at BIN_W = 14. Inputs are driven and
// outputs sampled 1 time unit after each rising clock edge.
module tb_bin2bcd16_8421;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] bin;
  logic [15:0] Y;
  logic        ovf;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [15:0] last_exp;

  bin2bcd16_8421 #(.BIN_W(14)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .Y     (Y),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] bcd(input int v);
    logic [3:0] d3, d2, d1, d0;
    d0 = 4'(v % 10);
    d1 = 4'((v / 10) % 10);
    d2 = 4'((v / 100) % 10);
    d3 = 4'((v / 1000) % 10);
    return {d3, d2, d1, d0};
  endfunction

  function automatic logic [15:0] exp_y(input int v);
`ifdef BIN2BCD_SAT_EN
    if (v > 9999) return 16'h9999;
`endif
    return bcd(v % 10000);
  endfunction

  // Called in an IDLE cycle; returns in the IDLE cycle after DONE (cycle 16).
  task automatic conv(input int v, input logic [15:0] ey, input logic eo, input string tag);
    int bad;
    start = 1'b1;
    bin   = 14'(v);
    step();
    start = 1'b0;
    bin   = 14'($urandom_range(0, 16383));
    bad   = 0;
    for (int c = 1; c <= 14; c++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      if (c == 7 && Y !== last_exp) bad++;
      step();
    end
    chk({tag, "_busy_window"}, 32'(bad), 32'd0);
    chk({tag, "_done15"}, 32'(done), 32'd1);
    chk({tag, "_busy15"}, 32'(busy), 32'd0);
    chk({tag, "_y"}, 32'(Y), 32'(ey));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    last_exp = ey;
    step();
    chk({tag, "_done16"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [13:0] hv [3];
    int          dcnt;
    hv = '{14'd4095, 14'd777, 14'd9000};

    // Reset with start held high: reset must win.
    rst_n = 1'b0;
    start = 1'b1;
    bin   = 14'd1234;
    last_exp = 16'h0000;
    step();
    step();
    chk("rst_y", 32'(Y), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    conv(0, 16'h0000, 1'b0, "zero");
    conv(9999, 16'h9999, 1'b0, "v9999");
    conv(1234, 16'h1234, 1'b0, "v1234");
    conv(5678, 16'h5678, 1'b0, "v5678");
`ifdef BIN2BCD_SAT_EN
    conv(10000, 16'h9999, 1'b1, "v10000");
    conv(16383, 16'h9999, 1'b1, "v16383");
`else
    conv(10000, 16'h0000, 1'b1, "v10000");
    conv(16383, 16'h6383, 1'b1, "v16383");
`endif
    conv(1, 16'h0001, 1'b0, "v1");

    // start held high, bin wandering: accepts only at IDLE edges, period 16.
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bin = hv[k];
      step();
      chk("held_busy1", 32'(busy), 32'd1);
      for (int c = 2; c <= 15; c++) begin
        bin = 14'($urandom_range(0, 16383));
        if (c == 7) chk("held_y_stable", 32'(Y), 32'(last_exp));
        step();
      end
      chk("held_done15", 32'(done), 32'd1);
      chk("held_y", 32'(Y), 32'(bcd(int'(hv[k]))));
      chk("held_ovf", 32'(ovf), 32'd0);
      last_exp = bcd(int'(hv[k]));
      step();
      chk("held_done16", 32'(done), 32'd0);
      chk("held_busy16", 32'(busy), 32'd0);
    end
    start = 1'b0;

    // Reset at SHIFT cycle 7 aborts the conversion.
    start = 1'b1;
    bin   = 14'd4321;
    step();
    start = 1'b0;
    repeat (6) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_y", 32'(Y), 32'h0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    dcnt = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) dcnt++;
    end
    chk("abort_quiet", 32'(dcnt), 32'd0);
    last_exp = 16'h0000;
    conv(4321, 16'h4321, 1'b0, "after_abort");

    // Sparse sweep of the in-range operands.
    for (int v = 0; v <= 9999; v += 41) begin
      conv(v, bcd(v), 1'b0, "sweep");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
